// File: rtl/frame_stream_ctrl_pkg.sv
// Shared types and constants for the frame capture to AXI-Stream bridge.
// Holds the controller state encoding and the fixed AXIS framing constants.
package frame_stream_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    localparam int         AXIS_W    = 32;
    localparam logic [3:0] TKEEP_ALL = 4'hF;

endpackage

// File: rtl/frame_stream_ctrl_stream_fifo.sv
// Synchronous first-word-fall-through FIFO; a push is visible at the head one cycle later.
// Backpressure: a push while full is accepted only when a pop happens in the same cycle.
module stream_fifo #(
    parameter int W  = 13,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 2 ** AW;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         wr_en;
    logic         rd_en;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // When full, the slot being written is the one being popped this cycle.
    assign wr_en   = push && (!full || pop);
    assign rd_en   = pop && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/frame_stream_ctrl.sv
// Capture-session sequencer moving frame beats onto AXIS S2MM; beat at N appears on m_tvalid at N+1 when empty.
// Upstream cannot stall: beats hitting a full FIFO are dropped and flagged in Overflow.
module frame_stream_ctrl
    import frame_stream_ctrl_pkg::*;
#(
    parameter int DATA_SIZE   = 12,
    parameter int LENGTH      = 32768,
    parameter int LENGTH_SIZE = 15,
    parameter int FIFO_ADD    = 4,
    parameter int FRAME_W     = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   StartColl,
    input  logic                   Abort,
    input  logic [FRAME_W-1:0]     FrameNum,
    output logic                   Collect,
    input  logic [DATA_SIZE-1:0]   FramData,
    input  logic [LENGTH_SIZE-1:0] FramAdd,
    input  logic                   FramEn,
    output logic [AXIS_W-1:0]      m_tdata,
    output logic [3:0]             m_tkeep,
    output logic                   m_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Overflow,
    output logic                   SeqErr,
    output logic [FRAME_W-1:0]     FrameCnt
);

    localparam logic [LENGTH_SIZE-1:0] LAST_IDX = LENGTH_SIZE'(LENGTH - 1);

    state_t                 state;
    logic                   start_q;
    logic                   in_frame;
    logic                   seq_vld;
    logic [LENGTH_SIZE-1:0] exp_idx;

    logic                   start_rise;
    logic                   is_first;
    logic                   is_last;
    logic                   accept;
    logic                   pop;
    logic                   drop;
    logic                   cnt_hit;
    logic [FRAME_W:0]       cnt_nxt;
    logic [LENGTH_SIZE-1:0] nxt_idx;
    logic [DATA_SIZE:0]     head_dat;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign start_rise = StartColl && !start_q;
    assign is_first   = (FramAdd == '0);
    assign is_last    = (FramAdd == LAST_IDX);
    assign nxt_idx    = is_last ? '0 : FramAdd + LENGTH_SIZE'(1);

    // A new frame is not started once StartColl has dropped, so a stop never leaves a partial frame.
    assign accept  = (state == ST_COLLECT) && FramEn && !Abort &&
                     (in_frame || (is_first && StartColl));
    assign pop     = m_tvalid && m_tready;
    assign drop    = accept && fifo_full && !pop;
    assign cnt_nxt = {1'b0, FrameCnt} + (FRAME_W+1)'(1);
    assign cnt_hit = (FrameNum != '0) && (cnt_nxt == {1'b0, FrameNum});

    stream_fifo #(
        .W  (DATA_SIZE + 1),
        .AW (FIFO_ADD)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (Abort),
        .push     (accept),
        .push_dat ({is_last, FramData}),
        .pop      (pop),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign m_tvalid = !fifo_empty;
    assign m_tlast  = !fifo_empty && head_dat[DATA_SIZE];
    assign m_tdata  = fifo_empty ? '0 : {{(AXIS_W-DATA_SIZE){1'b0}}, head_dat[DATA_SIZE-1:0]};
    assign m_tkeep  = TKEEP_ALL;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            start_q  <= 1'b0;
            in_frame <= 1'b0;
            seq_vld  <= 1'b0;
            exp_idx  <= '0;
            Collect  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Overflow <= 1'b0;
            SeqErr   <= 1'b0;
            FrameCnt <= '0;
        end else begin
            start_q <= StartColl;
            if (Abort) begin
                state    <= ST_IDLE;
                Collect  <= 1'b0;
                Busy     <= 1'b0;
                in_frame <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_rise) begin
                            state <= ST_ARM;
                            Busy  <= 1'b1;
                        end
                    end
                    ST_ARM: begin
                        Done     <= 1'b0;
                        Overflow <= 1'b0;
                        SeqErr   <= 1'b0;
                        FrameCnt <= '0;
                        in_frame <= 1'b0;
                        seq_vld  <= 1'b0;
                        Collect  <= 1'b1;
                        state    <= ST_COLLECT;
                    end
                    ST_COLLECT: begin
                        if (drop) Overflow <= 1'b1;
                        if (accept) begin
                            // The first checked beat of a session only seeds the expected index.
                            seq_vld <= 1'b1;
                            exp_idx <= nxt_idx;
                            if (seq_vld && (FramAdd != exp_idx)) SeqErr <= 1'b1;
                            if (is_last) begin
                                in_frame <= 1'b0;
                                if (FrameCnt != '1) FrameCnt <= cnt_nxt[FRAME_W-1:0];
                                if (cnt_hit) begin
                                    state   <= ST_DRAIN;
                                    Collect <= 1'b0;
                                end
                            end else if (is_first) begin
                                in_frame <= 1'b1;
                            end
                        end
                        if (!StartColl && !in_frame) begin
                            state   <= ST_DRAIN;
                            Collect <= 1'b0;
                        end
                    end
                    ST_DRAIN: begin
                        if (fifo_empty) begin
                            state <= ST_IDLE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// Scoreboard bench for frame_stream_ctrl with 16-beat frames.
// Driven beats expected on AXIS are queued and popped on each handshake.
module tb_frame_stream_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        StartColl;
    logic        Abort;
    logic [7:0]  FrameNum;
    logic        Collect;
    logic [11:0] FramData;
    logic [3:0]  FramAdd;
    logic        FramEn;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic        Busy;
    logic        Done;
    logic        Overflow;
    logic        SeqErr;
    logic [7:0]  FrameCnt;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_out = 0;
    int          n_last = 0;
    logic [12:0] sb [$];
    logic [12:0] sb_head;

    frame_stream_ctrl #(
        .DATA_SIZE   (12),
        .LENGTH      (16),
        .LENGTH_SIZE (4),
        .FIFO_ADD    (4),
        .FRAME_W     (8)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .StartColl (StartColl),
        .Abort     (Abort),
        .FrameNum  (FrameNum),
        .Collect   (Collect),
        .FramData  (FramData),
        .FramAdd   (FramAdd),
        .FramEn    (FramEn),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .Busy      (Busy),
        .Done      (Done),
        .Overflow  (Overflow),
        .SeqErr    (SeqErr),
        .FrameCnt  (FrameCnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && m_tvalid && m_tready) begin
            n_out++;
            if (m_tlast) n_last++;
            if (sb.size() == 0) begin
                check_eq("sb_extra_beat", {31'b0, m_tvalid}, 32'd0);
            end else begin
                sb_head = sb.pop_front();
                check_eq("sb_data", m_tdata, {20'b0, sb_head[11:0]});
                check_eq("sb_last", {31'b0, m_tlast}, {31'b0, sb_head[12]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] dv(input int t, input int f, input int a);
        return {4'(t), 4'(f), 4'(a)};
    endfunction

    task automatic beat(input int a, input logic [11:0] d, input bit exp);
        FramEn   = 1'b1;
        FramAdd  = 4'(a);
        FramData = d;
        if (exp) sb.push_back({(a == 15), d});
        tick();
        FramEn = 1'b0;
    endtask

    task automatic frame(input int t, input int f, input int lo, input int hi, input bit exp);
        for (int a = lo; a <= hi; a++) beat(a, dv(t, f, a), exp);
    endtask

    task automatic start_session(input logic [7:0] fn);
        int n;
        StartColl = 1'b0;
        FrameNum  = fn;
        tick();
        tick();
        StartColl = 1'b1;
        n = 0;
        while (!Collect && n < 20) begin
            tick();
            n++;
        end
        check_eq("collect_up", {31'b0, Collect}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!Done && n < 500) begin
            tick();
            n++;
        end
        check_eq(tag, {31'b0, Done}, 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0;
        int l0;
        rstn = 1'b0; StartColl = 1'b0; Abort = 1'b0; FrameNum = 8'd0;
        FramData = '0; FramAdd = '0; FramEn = 1'b0; m_tready = 1'b1;
        repeat (3) tick();
        check_eq("rst_collect",  {31'b0, Collect},  32'd0);
        check_eq("rst_tvalid",   {31'b0, m_tvalid}, 32'd0);
        check_eq("rst_busy",     {31'b0, Busy},     32'd0);
        check_eq("rst_done",     {31'b0, Done},     32'd0);
        check_eq("rst_overflow", {31'b0, Overflow}, 32'd0);
        check_eq("rst_seqerr",   {31'b0, SeqErr},   32'd0);
        check_eq("rst_framecnt", {24'b0, FrameCnt}, 32'd0);
        check_eq("rst_tdata",    m_tdata,           32'd0);
        check_eq("rst_tkeep",    {28'b0, m_tkeep},  32'hF);
        rstn = 1'b1;
        tick();
        check_eq("idle_busy", {31'b0, Busy}, 32'd0);

        // Two-frame session stopping on FrameNum.
        o0 = n_out; l0 = n_last;
        start_session(8'd2);
        check_eq("t1_busy", {31'b0, Busy}, 32'd1);
        frame(1, 0, 0, 15, 1'b1);
        frame(1, 1, 0, 15, 1'b1);
        check_eq("t1_collect_low", {31'b0, Collect}, 32'd0);
        wait_done("t1_done");
        check_eq("t1_beats",    n_out - o0,         32'd32);
        check_eq("t1_tlasts",   n_last - l0,        32'd2);
        check_eq("t1_framecnt", {24'b0, FrameCnt},  32'd2);
        check_eq("t1_busy_end", {31'b0, Busy},      32'd0);
        check_eq("t1_sb_empty", sb.size(),          32'd0);

        // Mid-frame start: beats before index 0 are discarded.
        o0 = n_out;
        start_session(8'd1);
        frame(2, 0, 5, 15, 1'b0);
        frame(2, 1, 0, 15, 1'b1);
        wait_done("t2_done");
        check_eq("t2_beats",    n_out - o0,        32'd16);
        check_eq("t2_framecnt", {24'b0, FrameCnt}, 32'd1);
        check_eq("t2_sb_empty", sb.size(),         32'd0);

        // Long stall: FIFO fills, the second frame is dropped, head stays stable.
        o0 = n_out;
        m_tready = 1'b0;
        start_session(8'd0);
        frame(3, 0, 0, 15, 1'b1);
        frame(3, 1, 0, 15, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check_eq("t3_stall_tdata",  m_tdata,           {20'b0, dv(3, 0, 0)});
            check_eq("t3_stall_tvalid", {31'b0, m_tvalid}, 32'd1);
            tick();
        end
        check_eq("t3_overflow", {31'b0, Overflow}, 32'd1);
        check_eq("t3_framecnt", {24'b0, FrameCnt}, 32'd2);
        m_tready  = 1'b1;
        StartColl = 1'b0;
        wait_done("t3_done");
        check_eq("t3_beats",    n_out - o0,        32'd16);
        check_eq("t3_seqerr",   {31'b0, SeqErr},   32'd0);
        check_eq("t3_sb_empty", sb.size(),         32'd0);

        // Stop request mid-frame: the frame completes, no further frame starts.
        o0 = n_out;
        start_session(8'd0);
        check_eq("t4_overflow_cleared", {31'b0, Overflow}, 32'd0);
        frame(4, 0, 0, 7, 1'b1);
        StartColl = 1'b0;
        frame(4, 0, 8, 15, 1'b1);
        frame(4, 1, 0, 3, 1'b0);
        check_eq("t4_collect_low", {31'b0, Collect}, 32'd0);
        wait_done("t4_done");
        check_eq("t4_beats",    n_out - o0,        32'd16);
        check_eq("t4_framecnt", {24'b0, FrameCnt}, 32'd1);
        check_eq("t4_sb_empty", sb.size(),         32'd0);

        // Address discontinuity 0,1,2,4,5...
        start_session(8'd1);
        frame(5, 0, 0, 2, 1'b1);
        check_eq("t5_seq_before", {31'b0, SeqErr}, 32'd0);
        beat(4, dv(5, 0, 4), 1'b1);
        check_eq("t5_seq_flag", {31'b0, SeqErr}, 32'd1);
        frame(5, 0, 5, 15, 1'b1);
        wait_done("t5_done");
        check_eq("t5_framecnt", {24'b0, FrameCnt}, 32'd1);
        check_eq("t5_sb_empty", sb.size(),         32'd0);

        // Abort with six beats buffered, then re-arm.
        m_tready = 1'b0;
        start_session(8'd0);
        frame(6, 0, 0, 2, 1'b1);
        frame(6, 0, 4, 6, 1'b1);
        check_eq("t6_seq_pre",    {31'b0, SeqErr},   32'd1);
        check_eq("t6_tvalid_pre", {31'b0, m_tvalid}, 32'd1);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        sb.delete();
        check_eq("t6_tvalid", {31'b0, m_tvalid}, 32'd0);
        check_eq("t6_busy",   {31'b0, Busy},     32'd0);
        check_eq("t6_done",   {31'b0, Done},     32'd0);
        check_eq("t6_collect",{31'b0, Collect},  32'd0);
        m_tready = 1'b1;
        repeat (3) tick();
        check_eq("t6_tvalid_hold", {31'b0, m_tvalid}, 32'd0);
        start_session(8'd1);
        check_eq("t6_rearm_seq",  {31'b0, SeqErr},   32'd0);
        check_eq("t6_rearm_ovf",  {31'b0, Overflow}, 32'd0);
        check_eq("t6_rearm_done", {31'b0, Done},     32'd0);
        check_eq("t6_rearm_cnt",  {24'b0, FrameCnt}, 32'd0);
        check_eq("t6_rearm_busy", {31'b0, Busy},     32'd1);
        frame(6, 1, 0, 15, 1'b1);
        wait_done("t6_done_end");
        check_eq("t6_framecnt", {24'b0, FrameCnt}, 32'd1);
        check_eq("t6_sb_empty", sb.size(),         32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
